// File: rtl/alu_multicycle.sv
// alu_multicycle: single-issue ALU with flags and an iterative shift-add multiplier.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   in_valid      operation request
//   in_ready      request can be accepted this cycle (low while multiplying)
//   data1, data2  WIDTH-bit operands
//   operation     5-bit opcode
//   set_flags     update flags from this operation
//   out_valid     one-cycle pulse: result/result_write valid
//   result        registered result, held between pulses
//   result_write  result targets a register (0 for TST/TEQ/CMP/CMN/undefined)
//   flags         {V, N, C, Z}
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [4:0]       operation,
  input  logic             set_flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_write,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_AND = 5'b00000, OP_EOR = 5'b00001, OP_SUB = 5'b00010,
                         OP_RSB = 5'b00011, OP_ADD = 5'b00100, OP_ADC = 5'b00101,
                         OP_SBC = 5'b00110, OP_RSC = 5'b00111, OP_TST = 5'b01000,
                         OP_TEQ = 5'b01001, OP_CMP = 5'b01010, OP_CMN = 5'b01011,
                         OP_ORR = 5'b01100, OP_MOV = 5'b01101, OP_BIC = 5'b01110,
                         OP_MVN = 5'b01111, OP_MUL = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             mul_sf_q, mul_sf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_write_q, result_write_d;
  logic [3:0]       flags_q, flags_d;

  // Shared adder: every add/subtract variant is x + y + cin, with subtraction
  // done by inverting the subtrahend so the carry-out is NOT borrow.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;

  always_comb begin
    add_x   = data1;
    add_y   = data2;
    add_cin = 1'b0;
    case (operation)
      OP_SUB, OP_CMP: begin add_y = ~data2; add_cin = 1'b1; end
      OP_SBC:         begin add_y = ~data2; add_cin = flags_q[1]; end
      OP_RSB:         begin add_x = data2; add_y = ~data1; add_cin = 1'b1; end
      OP_RSC:         begin add_x = data2; add_y = ~data1; add_cin = flags_q[1]; end
      OP_ADC:         add_cin = flags_q[1];
      default:        ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  logic [WIDTH-1:0] alu_res;
  logic             alu_write, alu_arith, alu_logic, alu_test;
  logic [3:0]       alu_flags;
  logic             alu_upd;

  always_comb begin
    alu_res   = '0;
    alu_write = 1'b1;
    alu_arith = 1'b0;
    alu_logic = 1'b0;
    alu_test  = 1'b0;
    case (operation)
      OP_AND: begin alu_res = data1 & data2;  alu_logic = 1'b1; end
      OP_EOR: begin alu_res = data1 ^ data2;  alu_logic = 1'b1; end
      OP_ORR: begin alu_res = data1 | data2;  alu_logic = 1'b1; end
      OP_MOV: begin alu_res = data2;          alu_logic = 1'b1; end
      OP_BIC: begin alu_res = data1 & ~data2; alu_logic = 1'b1; end
      OP_MVN: begin alu_res = ~data2;         alu_logic = 1'b1; end
      OP_TST: begin alu_res = data1 & data2;  alu_logic = 1'b1; alu_write = 1'b0; alu_test = 1'b1; end
      OP_TEQ: begin alu_res = data1 ^ data2;  alu_logic = 1'b1; alu_write = 1'b0; alu_test = 1'b1; end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_RSC: begin
        alu_res = add_sum[WIDTH-1:0]; alu_arith = 1'b1;
      end
      OP_CMP, OP_CMN: begin
        alu_res = add_sum[WIDTH-1:0]; alu_arith = 1'b1; alu_write = 1'b0; alu_test = 1'b1;
      end
      default: alu_write = 1'b0;
    endcase

    if (alu_arith)
      alu_flags = {add_v, alu_res[WIDTH-1], add_sum[WIDTH], alu_res == '0};
    else
      alu_flags = {flags_q[3], alu_res[WIDTH-1], flags_q[1], alu_res == '0};
    alu_upd = (alu_arith || alu_logic) && (set_flags || alu_test);
  end

  logic             is_mul;
  logic [WIDTH-1:0] mul_sum;

  assign is_mul  = MUL_EN && (operation == OP_MUL);
  assign mul_sum = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    acc_d          = acc_q;
    mul_sf_d       = mul_sf_q;
    result_d       = result_q;
    result_write_d = result_write_q;
    flags_d        = flags_q;
    case (state_q)
      S_MUL: begin
        acc_d   = mul_sum;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d        = S_DONE;
          result_d       = mul_sum;
          result_write_d = 1'b1;
          if (mul_sf_q)
            flags_d = {flags_q[3], mul_sum[WIDTH-1], flags_q[1], mul_sum == '0};
        end
      end
      default: begin
        // IDLE and DONE both accept; in_ready is high in both.
        state_d = S_IDLE;
        if (in_valid) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = CW'(WIDTH);
            mul_a_d  = data1;
            mul_b_d  = data2;
            acc_d    = '0;
            mul_sf_d = set_flags;
          end else begin
            state_d        = S_DONE;
            result_d       = alu_res;
            result_write_d = alu_write;
            if (alu_upd) flags_d = alu_flags;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      acc_q          <= '0;
      mul_sf_q       <= 1'b0;
      result_q       <= '0;
      result_write_q <= 1'b0;
      flags_q        <= 4'b0000;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      acc_q          <= acc_d;
      mul_sf_q       <= mul_sf_d;
      result_q       <= result_d;
      result_write_q <= result_write_d;
      flags_q        <= flags_d;
    end
  end

  assign in_ready     = (state_q != S_MUL);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign result_write = result_write_q;
  assign flags        = flags_q;

endmodule
